// File: rtl/frame_config_pkg.sv
// Shared constants, command helpers and state encoding for the frame configuration loader.
package frame_config_pkg;

  localparam logic [31:0] SYNC_WORD       = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD     = 32'hFAB0_FAB0;
  localparam logic [7:0]  CMD_WRITE_FRAME = 8'hC0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_DATA   = 2'd2,
    ST_STROBE = 2'd3
  } state_e;

  function automatic logic is_write_cmd(input logic [31:0] word);
    return (word[31:24] == CMD_WRITE_FRAME);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Binary frame index to one-hot write strobe, gated by an enable.
module frame_strobe_decoder #(
  parameter int unsigned Width = 20,
  parameter int unsigned IdxW  = 8
) (
  input  logic [IdxW-1:0]  index_i,
  input  logic             enable_i,
  output logic [Width-1:0] onehot_o
);

  // One-hot decode; indices beyond Width simply produce no strobe.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < Width; i++) begin
      onehot_o[i] = enable_i && (index_i == i[IdxW-1:0]);
    end
  end

endmodule

// File: rtl/frame_config_loader.sv
// Bitstream-driven frame loader: SYNC, then write-frame command/data pairs that
// produce a single-cycle one-hot strobe towards the tile configuration latches.
module frame_config_loader
  import frame_config_pkg::*;
#(
  parameter int unsigned  FrameBitsPerRow = 32,
  parameter int unsigned  MaxFramesPerCol = 20,
  parameter int unsigned  NumColumns      = 16,
  localparam int unsigned ColW            = (NumColumns > 1) ? $clog2(NumColumns) : 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [ColW-1:0]            FrameColumn,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       active,
  output logic                       error,
  output logic [15:0]                frame_count
);

  localparam logic [8:0] COL_LIMIT   = 9'(NumColumns);
  localparam logic [8:0] FRAME_LIMIT = 9'(MaxFramesPerCol);

  state_e                       state_q, state_d;
  logic [7:0]                   col_q, col_d;
  logic [7:0]                   frame_q, frame_d;
  logic [FrameBitsPerRow-1:0]   fdata_q, fdata_d;
  logic [ColW-1:0]              fcol_q, fcol_d;
  logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
  logic                         error_q, error_d;
  logic [15:0]                  count_q, count_d;

  logic                         accept_s;
  logic                         in_range_s;
  logic                         dec_en_s;
  logic [MaxFramesPerCol-1:0]   dec_onehot_s;

  assign accept_s   = in_valid && in_ready;
  assign in_range_s = ({1'b0, col_q} < COL_LIMIT) && ({1'b0, frame_q} < FRAME_LIMIT);
  assign dec_en_s   = (state_q == ST_DATA) && accept_s && in_range_s;

  frame_strobe_decoder #(
    .Width (MaxFramesPerCol),
    .IdxW  (8)
  ) u_strobe_decoder (
    .index_i  (frame_q),
    .enable_i (dec_en_s),
    .onehot_o (dec_onehot_s)
  );

  // Next-state and datapath update decisions.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    frame_d  = frame_q;
    fdata_d  = fdata_q;
    fcol_d   = fcol_q;
    strobe_d = '0;
    error_d  = error_q;
    count_d  = count_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s && (in_data == SYNC_WORD)) begin
          state_d = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (!accept_s) begin
          state_d = ST_CMD;
        end else if (in_data == DESYNC_WORD) begin
          state_d = ST_IDLE;
        end else if (is_write_cmd(in_data)) begin
          col_d   = in_data[23:16];
          frame_d = in_data[7:0];
          state_d = ST_DATA;
        end else begin
          error_d = 1'b1;
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (!accept_s) begin
          state_d = ST_DATA;
        end else if (in_range_s) begin
          // Payload is never interpreted, so SYNC/DESYNC values land here as data.
          fdata_d  = in_data;
          fcol_d   = col_q[ColW-1:0];
          strobe_d = dec_onehot_s;
          count_d  = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);
          state_d  = ST_STROBE;
        end else begin
          fdata_d = in_data;
          error_d = 1'b1;
          state_d = ST_CMD;
        end
      end
      ST_STROBE: begin
        state_d = ST_CMD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      col_q    <= 8'd0;
      frame_q  <= 8'd0;
      fdata_q  <= '0;
      fcol_q   <= '0;
      strobe_q <= '0;
      error_q  <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      frame_q  <= frame_d;
      fdata_q  <= fdata_d;
      fcol_q   <= fcol_d;
      strobe_q <= strobe_d;
      error_q  <= error_d;
      count_q  <= count_d;
    end
  end

  assign in_ready    = (state_q != ST_STROBE);
  assign active      = (state_q != ST_IDLE);
  assign FrameData   = fdata_q;
  assign FrameColumn = fcol_q;
  assign FrameStrobe = strobe_q;
  assign error       = error_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench: stimulus feeds a word-stream reference model that queues expected
// strobes; an independent monitor pops and compares whenever a strobe appears.
module tb_frame_config_loader;
  import frame_config_pkg::*;

  localparam int FB = 32;
  localparam int MF = 20;
  localparam int NC = 16;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic [FB-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FB-1:0] FrameData;
  logic [3:0]    FrameColumn;
  logic [MF-1:0] FrameStrobe;
  logic          active;
  logic          error;
  logic [15:0]   frame_count;

  frame_config_loader #(
    .FrameBitsPerRow (FB),
    .MaxFramesPerCol (MF),
    .NumColumns      (NC)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .FrameData   (FrameData),
    .FrameColumn (FrameColumn),
    .FrameStrobe (FrameStrobe),
    .active      (active),
    .error       (error),
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  col;
    logic [7:0]  frm;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          rdy_low = 0;
  bit          win = 1'b0;
  time         t_first = 0;
  time         t_last = 0;

  // Reference model: the stream is either unsynchronised, waiting for a command,
  // or holding a command that the next word completes.
  bit          m_synced;
  bit          m_have_cmd;
  logic [7:0]  m_col;
  logic [7:0]  m_frm;
  logic [31:0] m_fdata;
  logic        m_err;
  logic [15:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_synced   = 1'b0;
    m_have_cmd = 1'b0;
    m_col      = 8'd0;
    m_frm      = 8'd0;
    m_fdata    = 32'd0;
    m_err      = 1'b0;
    m_cnt      = 16'd0;
    sb_q.delete();
  endfunction

  function automatic void model_accept(input logic [31:0] w);
    exp_t e;
    if (!m_synced) begin
      if (w == 32'hFAB0_FAB1) m_synced = 1'b1;
    end else if (!m_have_cmd) begin
      if (w == 32'hFAB0_FAB0) begin
        m_synced = 1'b0;
      end else if (w[31:24] == 8'hC0) begin
        m_col      = w[23:16];
        m_frm      = w[7:0];
        m_have_cmd = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_have_cmd = 1'b0;
      m_fdata    = w;
      if (int'(m_frm) < MF && int'(m_col) < NC) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        e.col  = m_col;
        e.frm  = m_frm;
        e.data = w;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
      end else begin
        m_err = 1'b1;
      end
    end
  endfunction

  // Strobe monitor: every strobe cycle must match the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (resetn && FrameStrobe != '0) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got strobe 0x%0h, expected none at %0t", FrameStrobe, $time);
      end else begin
        e = sb_q.pop_front();
        check("strobe_onehot", 32'(FrameStrobe), 32'd1 << e.frm);
        check("strobe_column", 32'(FrameColumn), 32'(e.col));
        check("strobe_data", FrameData, e.data);
        check("strobe_count", 32'(frame_count), 32'(e.cnt));
        check("strobe_ready_low", 32'(in_ready), 32'd0);
      end
    end
  end

  always @(negedge CLK) begin
    if (win && !in_ready) rdy_low++;
  end

  task automatic send(input logic [31:0] w);
    int waitc = 0;
    @(negedge CLK);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && waitc < 8) begin
      @(negedge CLK);
      waitc++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready stuck at 0, expected 1 within 8 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge CLK);
      model_accept(w);
      t_last = $time;
    end
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_active"}, 32'(active), 32'(m_synced));
    check({tag, "_error"}, 32'(error), 32'(m_err));
    check({tag, "_count"}, 32'(frame_count), 32'(m_cnt));
    check({tag, "_fdata"}, FrameData, m_fdata);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    resetn   = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  col;
    logic [7:0]  frm;
    int          r;

    model_reset();
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_fdata", FrameData, 32'd0);
    check("rst_fcol", 32'(FrameColumn), 32'd0);
    check("rst_strobe", 32'(FrameStrobe), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    @(negedge CLK);
    resetn = 1'b1;

    // Basic frame write to column 3, frame 5.
    send(32'hFAB0_FAB1);
    send(32'hC003_0005);
    send(32'hDEAD_BEEF);
    idle(2);
    check_state("basic");
    check("basic_fcol_hold", 32'(FrameColumn), 32'd3);
    check("basic_count_one", 32'(frame_count), 32'd1);

    // Commands without SYNC are discarded.
    do_reset();
    send(32'hC000_0001);
    send(32'h1234_5678);
    idle(2);
    check_state("nosync");

    // Out-of-range frame sets error, then a legal write still works.
    send(32'hFAB0_FAB1);
    send(32'hC000_0014);
    send(32'h0000_0000);
    idle(2);
    check_state("badframe");
    send(32'hC000_0000);
    send(32'h0000_00A5);
    idle(2);
    check_state("afterbad");

    // DESYNC as payload, then as a control word.
    do_reset();
    send(32'hFAB0_FAB1);
    send(32'hC001_0002);
    send(32'hFAB0_FAB0);
    idle(2);
    check_state("desync_data");
    send(32'hFAB0_FAB0);
    idle(2);
    check_state("desync_ctl");

    // Reset during the strobe cycle aborts the frame.
    do_reset();
    send(32'hFAB0_FAB1);
    send(32'hC002_0003);
    send(32'h1111_2222);
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    check("midrst_strobe", 32'(FrameStrobe), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_count", 32'(frame_count), 32'd0);
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    send(32'hC000_0000);
    send(32'h0000_5555);
    idle(2);
    check_state("midrst_resync");

    // Continuous command/data pairs: one stall cycle per frame.
    do_reset();
    send(32'hFAB0_FAB1);
    idle(1);
    rdy_low = 0;
    win = 1'b1;
    for (int i = 0; i < 10; i++) begin
      col = 8'($urandom_range(0, NC - 1));
      frm = 8'($urandom_range(0, MF - 1));
      send({8'hC0, col, 8'($urandom), frm});
      if (i == 0) t_first = t_last;
      send($urandom);
    end
    idle(3);
    win = 1'b0;
    check("burst_ready_low", 32'(rdy_low), 32'd10);
    check("burst_span", 32'((t_last - t_first) / 10), 32'd28);
    check_state("burst");
    check("burst_count", 32'(frame_count), 32'd10);

    // Randomised word stream with random valid gaps.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       w = 32'hFAB0_FAB1;
        1:       w = 32'hFAB0_FAB0;
        2, 3, 4, 5, 6:
                 w = {8'hC0, 8'($urandom_range(0, 17)), 8'($urandom), 8'($urandom_range(0, 22))};
        default: w = $urandom;
      endcase
      send(w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check_state("random");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
